// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB constants and packet type
// Purpose: widths, unit count and the CDB packet struct shared by the
// arbiter, the ROB CDB port and the reservation-station wakeup ports.
// Ports: none (package).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_ADDR_LEN
`define ROB_ADDR_LEN 6
`endif

package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU = 4;
  localparam int CDB_XLEN   = `XLEN;
  localparam int CDB_TAG_W  = `ROB_ADDR_LEN;

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  result;
  } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - functional-unit offer bus and CDB broadcast bus
// Purpose: bundles the per-unit valid/ready offers and the registered CDB.
// Ports: master = functional-unit / consumer side, slave = arbiter side.
//   fu_valid/fu_tag/fu_result  offers from the units
//   fu_ready                   offer accepted this cycle
//   cdb_valid/cdb_tag/cdb_result/cdb_grant_fu  broadcast outputs
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int XLEN   = CDB_XLEN,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int IDX_W  = $clog2(NUM_FU)
);
  logic [NUM_FU-1:0]            fu_valid;
  logic [NUM_FU-1:0][TAG_W-1:0] fu_tag;
  logic [NUM_FU-1:0][XLEN-1:0]  fu_result;
  logic [NUM_FU-1:0]            fu_ready;
  logic                         cdb_valid;
  logic [TAG_W-1:0]             cdb_tag;
  logic [XLEN-1:0]              cdb_result;
  logic [IDX_W-1:0]             cdb_grant_fu;

  modport master (
    output fu_valid, fu_tag, fu_result,
    input  fu_ready, cdb_valid, cdb_tag, cdb_result, cdb_grant_fu
  );

  modport slave (
    input  fu_valid, fu_tag, fu_result,
    output fu_ready, cdb_valid, cdb_tag, cdb_result, cdb_grant_fu
  );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// rtl/cdb_arbiter_rr_picker.sv - combinational round-robin priority encoder
// Purpose: picks the first requester at or above ptr, wrapping around.
// Ports: req (request vector), ptr (search start), grant (one-hot),
//   idx (encoded grant), any_grant (some request was present).
module cdb_arbiter_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any_grant
);
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int k = 0; k < N; k++) begin
      // ptr is always < N, so a single subtraction is enough to wrap.
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any_grant && req[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        idx       = j[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter for the common data bus
// Purpose: each unit hands a result into a one-entry buffer; one full
// buffer per cycle is chosen round-robin and broadcast on registered outputs.
// Ports: clk, reset (sync active-high), flush (same effect as reset on
//   buffers, cdb_valid and pointer), bus (cdb_arbiter_if slave side).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int XLEN   = CDB_XLEN,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int IDX_W  = $clog2(NUM_FU)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  cdb_arbiter_if.slave bus
);
  logic [NUM_FU-1:0]            buf_valid;
  logic [NUM_FU-1:0][TAG_W-1:0] buf_tag;
  logic [NUM_FU-1:0][XLEN-1:0]  buf_result;
  logic [IDX_W-1:0]             rr_ptr;

  logic [NUM_FU-1:0]            grant;
  logic [IDX_W-1:0]             grant_idx;
  logic                         any_grant;
  logic [NUM_FU-1:0]            ready;
  logic [NUM_FU-1:0]            take;

  logic                         cdb_valid_q;
  logic [TAG_W-1:0]             cdb_tag_q;
  logic [XLEN-1:0]              cdb_result_q;
  logic [IDX_W-1:0]             cdb_grant_q;

  cdb_arbiter_rr_picker #(.N(NUM_FU), .IW(IDX_W)) u_picker (
    .req       (buf_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (grant_idx),
    .any_grant (any_grant)
  );

  // A granted buffer empties on this edge, so it can refill at once; this
  // is what lets a single unit stream one packet per cycle.
  assign ready = (reset || flush) ? '0 : (~buf_valid | grant);
  assign take  = bus.fu_valid & ready;

  assign bus.fu_ready     = ready;
  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_tag      = cdb_tag_q;
  assign bus.cdb_result   = cdb_result_q;
  assign bus.cdb_grant_fu = cdb_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid    <= '0;
      rr_ptr       <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_result_q <= '0;
      cdb_grant_q  <= '0;
    end else if (flush) begin
      buf_valid   <= '0;
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      cdb_valid_q <= any_grant;
      if (any_grant) begin
        cdb_tag_q    <= buf_tag[grant_idx];
        cdb_result_q <= buf_result[grant_idx];
        cdb_grant_q  <= grant_idx;
        rr_ptr       <= (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (take[i]) begin
          buf_valid[i]  <= 1'b1;
          buf_tag[i]    <= bus.fu_tag[i];
          buf_result[i] <= bus.fu_result[i];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule
